// File: rtl/wca_irq_pkg.sv
// Shared types and constants for the interrupt event scheduler.
package wca_irq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StHoldoff = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 16;

    // Index width for n sources, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wca_rr_pick.sv
// Combinational priority picker: rotating search after ptr, or fixed highest-index-wins.
module wca_rr_pick
    import wca_irq_pkg::*;
#(
    parameter int unsigned NUM_EVT = 8,
    parameter int unsigned IDX_W   = clog2(NUM_EVT)
) (
    input  logic [NUM_EVT-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               rr_en,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_EVT-1:0] gnt
);

    logic               found;
    logic [NUM_EVT-1:0] rot;
    int unsigned        c;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        rot   = '0;
        c     = 0;
        if (rr_en) begin
            // Search upward from ptr+1, wrapping, first hit wins.
            for (int unsigned k = 1; k <= NUM_EVT; k++) begin
                c   = (int'(ptr) + k) % NUM_EVT;
                rot = req >> c;
                if (!found && rot[0]) begin
                    found = 1'b1;
                    idx   = IDX_W'(c);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_EVT; i++) begin
                rot = req >> i;
                if (rot[0]) begin
                    idx = IDX_W'(i);
                end
            end
        end
        gnt = NUM_EVT'(|req) << idx;
    end

endmodule

// File: rtl/wca_irq_scheduler.sv
// Latches enabled event requests and serves them one at a time on the interrupt interface,
// with ack/timeout retire and a holdoff gap between grants.
module wca_irq_scheduler
    import wca_irq_pkg::*;
#(
    parameter int unsigned NUM_EVT        = 8,
    parameter int unsigned RR_ARB         = 1,
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT    = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_EVT-1:0] src_evt,
    input  logic [NUM_EVT-1:0] enable,
    input  logic               irq_ack,
    input  logic               ovf_clr,
    output logic [NUM_EVT-1:0] irq_evt,
    output logic               irq_valid,
    output logic [2:0]         irq_id,
    output logic [NUM_EVT-1:0] pending,
    output logic [NUM_EVT-1:0] ovf_flags,
    output logic               timeout_flag
);

    localparam int unsigned IDX_W = clog2(NUM_EVT);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] HO_LIM = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_EVT-1:0] irq_evt_q, pending_q, pending_d, ovf_q, ovf_d;
    logic [NUM_EVT-1:0] req_set, in_svc, pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic [2:0]         irq_id_q;
    logic               irq_valid_q, tof_q, tof_d;
    logic               ack_hit, to_hit, retire;

    wca_rr_pick #(
        .NUM_EVT (NUM_EVT),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (pending_q),
        .ptr   (ptr_q),
        .rr_en (RR_ARB != 0),
        .idx   (pick_idx),
        .gnt   (pick_gnt)
    );

    assign ack_hit = (state_q == StAssert) && irq_ack;
    assign to_hit  = (ACK_TIMEOUT != 0) && (state_q == StAssert) && (cnt_q == TO_LIM);
    assign retire  = ack_hit || to_hit;

    always_comb begin
        in_svc    = (state_q == StAssert) ? irq_evt_q : '0;
        req_set   = src_evt & enable;
        // Disabled bits drop, but the in-service bit survives until its retire.
        pending_d = pending_q & (enable | in_svc);
        if (retire) begin
            pending_d = pending_d & ~irq_evt_q;
        end
        pending_d = pending_d | req_set;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | (req_set & pending_q & ~in_svc);
        tof_d     = (ovf_clr ? 1'b0 : tof_q) | (to_hit && !irq_ack);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            ovf_q     <= '0;
            tof_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            tof_q     <= tof_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ptr_q       <= IDX_W'(NUM_EVT - 1);
            irq_evt_q   <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|pending_q) begin
                        state_q     <= StAssert;
                        irq_evt_q   <= pick_gnt;
                        irq_valid_q <= 1'b1;
                        irq_id_q    <= 3'(pick_idx);
                        ptr_q       <= pick_idx;
                        cnt_q       <= '0;
                    end
                end
                StAssert: begin
                    if (retire) begin
                        irq_evt_q   <= '0;
                        irq_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= (HOLDOFF_CYCLES == 0) ? StIdle : StHoldoff;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHoldoff: begin
                    if (cnt_q == HO_LIM) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign irq_evt      = irq_evt_q;
    assign irq_valid    = irq_valid_q;
    assign irq_id       = irq_id_q;
    assign pending      = pending_q;
    assign ovf_flags    = ovf_q;
    assign timeout_flag = tof_q;

endmodule
